fft_frame_writer: RTL and testbench
===================================

// Module: fft_frame_writer
// PURPOSE
//  Producer side of the FFT capture RAM write port. Takes a valid-qualified sample stream and writes
//  gap-free DEPTH-sample frames using the RAM's wren/arm_read protocol; each completed frame is handed
//  to the read buffer. Supports an optional trigger, single-shot or continuous capture, and holdoff.
//  Sits between the ADC/decimator stream and the capture RAM in the FFT front end.
// PARAMETERS
//  WIDTH    16                 sample width, bits
//  DEPTH    1024               samples per frame; must equal the RAM DEPTH
//  WDDRM    $clog2(DEPTH)      sample-index width
//  HOLDOFF  DEPTH+2            idle cycles after handoff before re-arming (RAM read-out time); 0 allowed
// PORTS
//  clk        in   1      clock; all logic on the rising edge
//  rst_n      in   1      asynchronous reset, active low
//  start      in   1      1-cycle pulse: arm a capture (ignored unless IDLE)
//  stop       in   1      1-cycle pulse: abort from any state, return to IDLE
//  cont       in   1      1: re-arm automatically after holdoff; 0: single shot
//  trig_en    in   1      1: each frame waits for a trig rising edge; 0: free-run
//  trig       in   1      trigger level, synchronous to clk
//  s_valid    in   1      input sample valid
//  s_data     in   WIDTH  input sample, two's complement
//  s_ready    out  1      1 while samples are accepted (FILL only)
//  wren       out  1      RAM write control: 0 = write wrdata at the next address; 1 = address reset
//  arm_read   out  1      1-cycle handoff strobe (asserted together with wren=1)
//  wrdata     out  WIDTH  RAM write data
//  busy       out  1      state != IDLE
//  frame_done out  1      1-cycle pulse, coincident with arm_read
//  gap_err    out  1      1-cycle pulse when a frame is aborted on an input gap
//  frame_cnt  out  16     completed frames, wraps at 0xFFFF -> 0
//  abort_cnt  out  8      aborted frames, saturates at 0xFF
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; wren=1, arm_read=0, wrdata=0, s_ready=0, busy=0, frame_done=0,
//   gap_err=0, frame_cnt=0, abort_cnt=0, sample and holdoff counters=0. Applies immediately, including
//   mid-frame; the partial frame is discarded and never handed off.
//  All outputs are registered. wren=1 and arm_read=0 in every cycle not described below.
//  States: IDLE -> (start) ARM -> FILL -> HANDOFF -> HOLD -> (cont ? ARM : IDLE).
//  ARM: trig_en=0 -> FILL on the next edge. trig_en=1 -> FILL on the edge where trig=1 and was 0 the
//   previous cycle. A trig edge seen in the same cycle ARM is entered is ignored.
//  FILL: s_ready=1. A sample accepted at edge k (s_valid=1) drives wren=0, wrdata=s_data during cycle k+1.
//   The index counts 0..DEPTH-1. The frame starts on the first valid sample; idle cycles before it are
//   allowed. After at least one sample is taken, s_valid=0 is a gap: wren stays 1 (RAM address reset),
//   gap_err pulses, abort_cnt increments (saturating), the index clears, and state returns to ARM.
//  The sample with index DEPTH-1 accepted at edge k gives: cycle k+1 wren=0 (last write); cycle k+2 (HANDOFF)
//   wren=1, arm_read=1, frame_done=1, frame_cnt+1, s_ready=0; cycle k+3 arm_read=0, enter HOLD.
//  HOLD: holdoff counter runs HOLDOFF cycles, s_ready=0; HOLDOFF=0 leaves after 1 cycle. Exit goes to ARM
//   if cont=1, sampled on the exit edge, else to IDLE.
//  stop: top priority in any state; next cycle IDLE, wren=1, no arm_read. If stop arrives in the cycle
//   HANDOFF would begin, the handoff is suppressed and frame_cnt is unchanged. stop+start in the same
//   cycle: stop wins. start outside IDLE is ignored.
//  Samples offered while s_ready=0 are dropped without error.
//  Invariant: wren=0 never appears more than DEPTH cycles in a row, and arm_read=1 only follows exactly
//   DEPTH consecutive wren=0 cycles.
// TESTING
//  1 trig_en=0, cont=0, start, s_valid=1 with ramp 0..1023 -> 1024 consecutive wren=0 cycles carrying
//    0..1023, then 1 cycle of wren=1/arm_read=1/frame_done=1; frame_cnt=1, busy falls after HOLDOFF.
//  2 Gap: drop s_valid for 1 cycle after sample 500 -> gap_err pulse, abort_cnt=1, no arm_read; the
//    following frame delivers a clean 1024-sample ramp and frame_cnt=1.
//  3 trig_en=1, trig held high when entering ARM -> no capture; trig low then high -> FILL starts on
//    the next valid sample.
//  4 cont=1, HOLDOFF=4 -> handoffs exactly 1024+1+1+4+1 cycles apart with continuous input;
//    frame_cnt counts 1,2,3.
//  5 rst_n low at sample 300 -> outputs take reset values asynchronously; after release and start,
//    the capture begins at index 0.
//  6 stop together with the last sample -> no arm_read, IDLE, frame_cnt unchanged; 300 forced gaps
//    -> abort_cnt=0xFF.

Source files
------------

// File: rtl/fft_frame_writer.sv
// Producer side of the FFT capture RAM write port: packs a valid-qualified sample stream into
// gap-free DEPTH-sample frames and hands each completed frame to the reader with arm_read.
module fft_frame_writer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned WDDRM   = $clog2(DEPTH),
  parameter int unsigned HOLDOFF = DEPTH + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic             trig_en,
  input  logic             trig,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             wren,
  output logic             arm_read,
  output logic [WIDTH-1:0] wrdata,
  output logic             busy,
  output logic             frame_done,
  output logic             gap_err,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       abort_cnt
);

  localparam int unsigned      HCW      = $clog2(HOLDOFF + 1) + 1;
  localparam logic [WDDRM-1:0] LastIdx  = WDDRM'(DEPTH - 1);
  localparam logic [HCW-1:0]   HoldLast = HCW'(HOLDOFF);

  typedef enum logic [2:0] {StIdle, StArm, StFill, StHandoff, StHold} state_e;

  state_e           state_q, state_d;
  logic [WDDRM-1:0] idx_q, idx_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic             trig_q, trig_d;
  logic             s_ready_q, s_ready_d;
  logic             wren_q, wren_d;
  logic             arm_read_q, arm_read_d;
  logic [WIDTH-1:0] wrdata_q, wrdata_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             gap_err_q, gap_err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]       abort_cnt_q, abort_cnt_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    trig_d       = trig;
    wren_d       = 1'b1;
    arm_read_d   = 1'b0;
    frame_done_d = 1'b0;
    gap_err_d    = 1'b0;
    wrdata_d     = wrdata_q;
    frame_cnt_d  = frame_cnt_q;
    abort_cnt_d  = abort_cnt_q;

    if (stop) begin
      state_d = StIdle;
      idx_d   = '0;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_d = StArm;
        end
        StArm: begin
          if (!trig_en || (trig && !trig_q)) state_d = StFill;
        end
        StFill: begin
          if (s_valid) begin
            wren_d   = 1'b0;
            wrdata_d = s_data;
            if (idx_q == LastIdx) begin
              idx_d   = '0;
              state_d = StHandoff;
            end else begin
              idx_d = idx_q + WDDRM'(1);
            end
          end else if (idx_q != '0) begin
            // Gap inside a started frame: leave wren high so the RAM address resets.
            gap_err_d = 1'b1;
            if (abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
            idx_d   = '0;
            state_d = StArm;
          end
        end
        StHandoff: begin
          arm_read_d   = 1'b1;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          hold_d       = '0;
          state_d      = StHold;
        end
        StHold: begin
          // The handoff cycle itself counts as the first of HOLDOFF+1 hold cycles.
          if (hold_q == HoldLast) begin
            hold_d  = '0;
            state_d = cont ? StArm : StIdle;
          end else begin
            hold_d = hold_q + HCW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    s_ready_d = (state_d == StFill);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      hold_q       <= '0;
      trig_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      wren_q       <= 1'b1;
      arm_read_q   <= 1'b0;
      wrdata_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      gap_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
      abort_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      trig_q       <= trig_d;
      s_ready_q    <= s_ready_d;
      wren_q       <= wren_d;
      arm_read_q   <= arm_read_d;
      wrdata_q     <= wrdata_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      gap_err_q    <= gap_err_d;
      frame_cnt_q  <= frame_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign wren       = wren_q;
  assign arm_read   = arm_read_q;
  assign wrdata     = wrdata_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign gap_err    = gap_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign abort_cnt  = abort_cnt_q;

endmodule

// File: tb/tb_fft_frame_writer.sv
// Bench for fft_frame_writer: a frame-level reference model checked every cycle, a RAM-side
// capture of every handed-off frame, and directed plus random stimulus.
module tb_fft_frame_writer;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned HOLDOFF = 4;
  localparam int          PERIOD  = 1024 + 1 + 1 + 4 + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop, cont, trig_en, trig, s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready, wren, arm_read, busy, frame_done, gap_err;
  logic [WIDTH-1:0] wrdata;
  logic [15:0]      frame_cnt;
  logic [7:0]       abort_cnt;

  always #5 clk = ~clk;

  fft_frame_writer #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .cont      (cont),
    .trig_en   (trig_en),
    .trig      (trig),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .wren      (wren),
    .arm_read  (arm_read),
    .wrdata    (wrdata),
    .busy      (busy),
    .frame_done(frame_done),
    .gap_err   (gap_err),
    .frame_cnt (frame_cnt),
    .abort_cnt (abort_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the writer must be doing, expressed as capture phases and a frame queue.
  typedef enum int {PIdle, PArm, PFill, PLast, PHold} phase_e;
  phase_e           ph;
  logic [WIDTH-1:0] frame[$];
  logic [WIDTH-1:0] handed[$];
  int               hold_left;
  logic             trig_prev;
  logic             m_wren, m_arm, m_fd, m_gap, m_ready, m_busy;
  logic [WIDTH-1:0] m_wrdata;
  logic [15:0]      m_fcnt;
  logic [7:0]       m_acnt;

  task automatic model_reset();
    ph = PIdle; frame.delete(); hold_left = 0; trig_prev = 1'b0;
    m_wren = 1'b1; m_arm = 1'b0; m_fd = 1'b0; m_gap = 1'b0; m_ready = 1'b0; m_busy = 1'b0;
    m_wrdata = '0; m_fcnt = '0; m_acnt = '0;
  endtask

  task automatic model_step();
    m_wren = 1'b1; m_arm = 1'b0; m_fd = 1'b0; m_gap = 1'b0;
    if (stop) begin
      ph = PIdle;
      frame.delete();
    end else begin
      case (ph)
        PIdle: if (start) ph = PArm;
        PArm:  if (!trig_en || (trig && !trig_prev)) ph = PFill;
        PFill: begin
          if (s_valid) begin
            frame.push_back(s_data);
            m_wren = 1'b0;
            m_wrdata = s_data;
            if (frame.size() == DEPTH) begin
              handed = frame;
              frame.delete();
              ph = PLast;
            end
          end else if (frame.size() != 0) begin
            m_gap = 1'b1;
            if (m_acnt != 8'hFF) m_acnt = m_acnt + 8'd1;
            frame.delete();
            ph = PArm;
          end
        end
        PLast: begin
          m_arm = 1'b1; m_fd = 1'b1; m_fcnt = m_fcnt + 16'd1;
          hold_left = HOLDOFF;
          ph = PHold;
        end
        PHold: begin
          if (hold_left == 0) ph = cont ? PArm : PIdle;
          else hold_left--;
        end
        default: ph = PIdle;
      endcase
    end
    trig_prev = trig;
    m_ready = (ph == PFill);
    m_busy = (ph != PIdle);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare plus a RAM-side view of what each handoff delivers.
  logic [WIDTH-1:0] ram[$];
  logic [WIDTH-1:0] last_frame[$];
  int               cyc = 0;
  int               writes = 0, handoffs = 0, gaps = 0;
  int               hcyc[$];
  int               hfc[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    check("wren", 32'(wren), 32'(m_wren));
    check("arm_read", 32'(arm_read), 32'(m_arm));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("gap_err", 32'(gap_err), 32'(m_gap));
    check("s_ready", 32'(s_ready), 32'(m_ready));
    check("busy", 32'(busy), 32'(m_busy));
    check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    check("abort_cnt", 32'(abort_cnt), 32'(m_acnt));
    if (!m_wren) check("wrdata", 32'(wrdata), 32'(m_wrdata));
    if (gap_err) gaps++;
    if (wren === 1'b0) begin
      ram.push_back(wrdata);
      writes++;
    end else begin
      if (arm_read === 1'b1) begin
        int bad = 0;
        check("handoff_len", 32'(ram.size()), 32'(DEPTH));
        for (int i = 0; i < ram.size() && i < handed.size(); i++)
          if (ram[i] !== handed[i]) bad++;
        check("handoff_data", 32'(bad), 32'd0);
        last_frame = ram;
        handoffs++;
        hcyc.push_back(cyc);
        hfc.push_back(int'(frame_cnt));
      end
      ram.delete();
    end
  end

  int ramp_val = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; trig_en = 1'b0; trig = 1'b0;
    s_valid = 1'b0; s_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer a ramp with s_valid high; optionally drop s_valid once after gap_at samples.
  task automatic feed_ramp(input int ncyc, input int gap_at);
    bit gapped = 1'b0;
    bit acc;
    bit gap_now;
    for (int i = 0; i < ncyc; i++) begin
      gap_now = (gap_at >= 0) && !gapped && (ramp_val == gap_at) && s_ready;
      s_valid = !gap_now;
      s_data = WIDTH'(ramp_val);
      acc = s_ready && s_valid;
      tick();
      if (gap_now) begin
        gapped = 1'b1;
        ramp_val = 0;
      end
      if (acc) ramp_val++;
    end
    s_valid = 1'b0;
  endtask

  task automatic check_ramp(input string name);
    int bad = 0;
    check({name, "_len"}, 32'(last_frame.size()), 32'(DEPTH));
    foreach (last_frame[i]) if (last_frame[i] !== WIDTH'(i)) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  int h0, w0, g0;

  initial begin
    do_reset();
    check("rst_wren", 32'(wren), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_wrdata", 32'(wrdata), 32'd0);

    // 1: single-shot free-run ramp frame
    h0 = handoffs; w0 = writes; ramp_val = 0;
    pulse_start();
    feed_ramp(1040, -1);
    repeat (10) tick();
    check("t1_handoffs", 32'(handoffs - h0), 32'd1);
    check("t1_writes", 32'(writes - w0), 32'd1024);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check_ramp("t1_ramp");
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    tick();
    check("t1_stop_start_busy", 32'(busy), 32'd0);

    // 2: one-cycle gap after sample 500
    do_reset();
    h0 = handoffs; g0 = gaps; ramp_val = 0;
    pulse_start();
    feed_ramp(1600, 501);
    repeat (10) tick();
    check("t2_gap_pulses", 32'(gaps - g0), 32'd1);
    check("t2_abort_cnt", 32'(abort_cnt), 32'd1);
    check("t2_handoffs", 32'(handoffs - h0), 32'd1);
    check("t2_frame_cnt", 32'(frame_cnt), 32'd1);
    check_ramp("t2_ramp");

    // 3: trigger held high on entry must not fire
    do_reset();
    h0 = handoffs; w0 = writes; ramp_val = 0;
    trig_en = 1'b1; trig = 1'b1;
    pulse_start();
    feed_ramp(20, -1);
    check("t3_no_writes", 32'(writes - w0), 32'd0);
    check("t3_busy_armed", 32'(busy), 32'd1);
    trig = 1'b0;
    tick();
    trig = 1'b1;
    feed_ramp(1040, -1);
    repeat (10) tick();
    check("t3_frame_cnt", 32'(frame_cnt), 32'd1);
    check_ramp("t3_ramp");

    // 4: continuous capture, fixed handoff spacing
    do_reset();
    h0 = hcyc.size();
    cont = 1'b1;
    pulse_start();
    s_valid = 1'b1;
    for (int i = 0; i < 3 * PERIOD + 50; i++) begin
      s_data = WIDTH'($urandom);
      tick();
    end
    s_valid = 1'b0;
    check("t4_handoffs_ge3", 32'(hcyc.size() - h0 >= 3), 32'd1);
    if (hcyc.size() - h0 >= 3) begin
      check("t4_spacing_1", 32'(hcyc[h0 + 1] - hcyc[h0]), 32'(PERIOD));
      check("t4_spacing_2", 32'(hcyc[h0 + 2] - hcyc[h0 + 1]), 32'(PERIOD));
      check("t4_fc_1", 32'(hfc[h0]), 32'd1);
      check("t4_fc_2", 32'(hfc[h0 + 1]), 32'd2);
      check("t4_fc_3", 32'(hfc[h0 + 2]), 32'd3);
    end
    cont = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // 5: asynchronous reset in mid-frame
    do_reset();
    ramp_val = 0;
    pulse_start();
    feed_ramp(302, -1);
    s_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_wren", 32'(wren), 32'd1);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_ready", 32'(s_ready), 32'd0);
    check("t5_async_wrdata", 32'(wrdata), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    s_valid = 1'b0;
    tick();
    h0 = handoffs; ramp_val = 0;
    pulse_start();
    feed_ramp(1040, -1);
    repeat (10) tick();
    check("t5_handoffs", 32'(handoffs - h0), 32'd1);
    check_ramp("t5_ramp");

    // 6a: stop alongside the last sample suppresses the handoff
    do_reset();
    h0 = handoffs; ramp_val = 0;
    pulse_start();
    feed_ramp(1024, -1);
    check("t6_ramp_pos", 32'(ramp_val), 32'd1023);
    s_valid = 1'b1; s_data = WIDTH'(ramp_val); stop = 1'b1;
    tick();
    stop = 1'b0; s_valid = 1'b0;
    repeat (10) tick();
    check("t6_no_handoff", 32'(handoffs - h0), 32'd0);
    check("t6_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);

    // 6b: abort counter saturation
    pulse_start();
    for (int i = 0; i < 700; i++) begin
      s_valid = 1'b1; s_data = WIDTH'($urandom);
      tick();
      s_valid = 1'b0;
      tick();
    end
    check("t6_abort_sat", 32'(abort_cnt), 32'hFF);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Random mix of controls and stream, checked against the model every cycle
    do_reset();
    for (int i = 0; i < 8000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      stop = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 299) == 0) cont = ~cont;
      if ($urandom_range(0, 999) == 0) trig_en = ~trig_en;
      if ($urandom_range(0, 29) == 0) trig = ~trig;
      s_valid = ($urandom_range(0, 1499) != 0);
      s_data = WIDTH'($urandom);
      tick();
    end
    start = 1'b0; stop = 1'b0; s_valid = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
